known_sinks_loader: RTL and testbench
=====================================

Name: known_sinks_loader

Overview:
- Upstream feeder of the sink-membership checker.
- Receives a known-sinks list frame as a byte stream and writes it into the byte-wide known-sinks memory region at addresses 0x00..0x1F, i.e. 16 entries of 16 bits each.
- Pads any unused entries with an invalid ID, then raises done so the checker can start its scan.
- Re-armed once per CLIQUE round by the start pulse.

Parameters:
- MAX_SINKS, 16: number of 16-bit entries in the region; the region spans 2*MAX_SINKS bytes.
- WORD_WIDTH, 16: node ID width.
- MEM_WIDTH, 8: memory data width.
- PAD_ID, 16'hFFFF: fill value for unused entries. Node ID 0xFFFF is reserved and never assigned to a node.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; aborts any operation and re-arms the loader to receive a new frame
- rx_data  input  8  frame byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready at a rising edge
- mem_addr  output  WORD_WIDTH  byte address to write
- mem_data  output  MEM_WIDTH  byte to write
- mem_wr  output  1  write strobe, one byte per asserted cycle
- sink_count  output  5  number of real entries stored, min(N,16)
- overflow  output  1  frame announced more than MAX_SINKS entries
- done  output  1  level signal: the region is fully written and valid

Behaviour:
- Frame format: byte 0 is the count N (0..255), followed by 2N ID bytes. Each ID is sent high byte first.
- Memory layout is big-endian per entry: entry k occupies byte 2k (high) and byte 2k+1 (low).
- Reset (reset=0), asynchronously:
  - state=IDLE; byte counter=0.
  - mem_wr=0, mem_addr=0, mem_data=0.
  - sink_count=0, overflow=0, done=0.
  - rx_ready becomes 1 once reset is released.
- States: IDLE, RECV, PAD, DONE.
- IDLE:
  - rx_ready=1.
  - On accepting the count byte: latch N, set sink_count=min(N,16), set overflow=(N>16), clear the byte counter.
  - If N=0 go to PAD with pad address 0; otherwise go to RECV.
- RECV:
  - rx_ready=1.
  - On the i-th accepted ID byte (i = 0..2N-1): if i<32, then in the next cycle mem_wr=1, mem_addr=i, mem_data=byte. If i>=32 the byte is consumed and discarded with no write.
  - After accepting byte 2N-1: if 2N<32 go to PAD with pad address 2N; otherwise go to DONE.
  - Gaps in rx_valid are allowed; mem_wr stays 0 on cycles with no transfer.
- PAD:
  - rx_ready=0.
  - Writes PAD_ID bytes (0xFF) at consecutive addresses, one per cycle, through 0x1F.
  - Goes to DONE the cycle after the 0x1F write is issued.
- DONE:
  - rx_ready=0; done=1 and held.
  - mem_wr=0 from the cycle done rises onward.
  - mem_addr, mem_data, sink_count and overflow hold their values.
- Write latency: the memory write is registered and appears one cycle after the byte is accepted.
- start:
  - Legal in any state. The next state is IDLE; done, overflow and sink_count are cleared.
  - Any write already registered in the start cycle still completes. No further writes occur.
  - rx_ready=0 during the cycle start=1, so a byte offered in that cycle is not accepted (start wins).
  - Memory contents left by an aborted frame are undefined until the next frame completes. Consumers must gate on done.
- reset asserted mid-frame: the frame is abandoned immediately and writes stop; the same memory caveat applies.
- Byte counter is 9 bits, covering up to 510 ID bytes. No wrap-around is possible.
- mem_addr never exceeds 0x1F under any frame.

Test Plan:
- Count=2, IDs 0x0105, 0x0A0B, rx_valid continuous -> writes 00:01, 01:05, 02:0A, 03:0B, then 0xFF at 0x04..0x1F on consecutive cycles; done=1 the cycle after the 0x1F write; sink_count=2, overflow=0.
- Count=0 -> 32 pad writes of 0xFF at 0x00..0x1F; done=1; sink_count=0.
- Count=16, IDs 0x0001..0x0010 with rx_valid toggling every other cycle -> exactly 32 data writes with no pad writes; mem_wr gaps match the input gaps; done=1 after byte 31 is accepted; rx_ready=0 afterwards.
- Count=20, 40 ID bytes -> first 32 bytes written, last 8 accepted (rx_ready=1) but not written; sink_count=16, overflow=1, done=1.
- start pulse in DONE, then count=1 with ID 0x0042 -> done drops the cycle after start; writes 00:00, 01:42, then pad 0x02..0x1F; done=1 again.
- reset pulled low after 3 ID bytes of a count=4 frame -> all outputs go to 0 asynchronously, no further mem_wr; after release, rx_ready=1 in IDLE and a new frame loads correctly.

Source files
------------

// File: rtl/known_sinks_loader.sv
// known_sinks_loader: loads a known-sinks frame into the 32-byte sink region, pads unused entries, then flags done.
module known_sinks_loader #(
  parameter int MAX_SINKS = 16,
  parameter int WORD_WIDTH = 16,
  parameter int MEM_WIDTH = 8,
  parameter logic [15:0] PAD_ID = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MEM_WIDTH-1:0]  rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [WORD_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_data,
  output logic                  mem_wr,
  output logic [4:0]            sink_count,
  output logic                  overflow,
  output logic                  done
);
  localparam logic [1:0] IDLE = 2'd0, RECV = 2'd1, PAD = 2'd2, DONE = 2'd3;
  localparam logic [8:0] BYTES = 9'(2 * MAX_SINKS);
  localparam logic [7:0] MAX_N = 8'(MAX_SINKS);
  logic [1:0] state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] n_q, n_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0] data_q, data_d;
  logic wr_q, wr_d, ovf_q, ovf_d, done_q, done_d;
  logic [4:0] sink_q, sink_d;
  logic xfer;
  logic [7:0] rx_byte;
  assign rx_byte = 8'(rx_data);
  // start wins over a byte offered in the same cycle
  assign rx_ready = reset && !start && (state_q == IDLE || state_q == RECV);
  assign xfer = rx_valid && rx_ready;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    n_d = n_q;
    wr_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    sink_d = sink_q;
    ovf_d = ovf_q;
    done_d = done_q;
    if (start) begin
      state_d = IDLE;
      cnt_d = '0;
      sink_d = '0;
      ovf_d = 1'b0;
      done_d = 1'b0;
    end else if (state_q == IDLE) begin
      if (xfer) begin
        n_d = rx_byte;
        sink_d = rx_byte > MAX_N ? 5'(MAX_SINKS) : 5'(rx_byte);
        ovf_d = rx_byte > MAX_N;
        cnt_d = '0;
        state_d = rx_byte == 8'd0 ? PAD : RECV;
      end
    end else if (state_q == RECV) begin
      if (xfer) begin
        wr_d = cnt_q < BYTES;
        addr_d = wr_d ? WORD_WIDTH'(cnt_q) : addr_q;
        data_d = wr_d ? rx_data : data_q;
        cnt_d = cnt_q + 9'd1;
        // cnt_d doubles as the first pad address when the list is short
        if (cnt_q == {n_q, 1'b0} - 9'd1) state_d = n_q < MAX_N ? PAD : DONE;
      end
    end else if (state_q == PAD) begin
      wr_d = 1'b1;
      addr_d = WORD_WIDTH'(cnt_q);
      data_d = MEM_WIDTH'(cnt_q[0] ? PAD_ID[7:0] : PAD_ID[15:8]);
      cnt_d = cnt_q + 9'd1;
      state_d = cnt_q == BYTES - 9'd1 ? DONE : PAD;
    end else begin
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      sink_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      wr_q <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
      sink_q <= sink_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
    end
  end
  assign mem_wr = wr_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign sink_count = sink_q;
  assign overflow = ovf_q;
  assign done = done_q;
endmodule

// File: tb/tb_known_sinks_loader.sv
// tb_known_sinks_loader: directed frames against a byte-level write log of the sink region.
module tb_known_sinks_loader;
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, mem_wr, overflow, done;
  logic [15:0] mem_addr;
  logic [7:0] mem_data;
  logic [4:0] sink_count;
  int checks = 0, failures = 0, nwr = 0, bad_addr = 0;
  logic [7:0] wmem [32];
  logic [7:0] exp_mem [32];

  known_sinks_loader dut (
    .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr(mem_wr),
    .sink_count(sink_count), .overflow(overflow), .done(done)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mem_wr) begin
    nwr++;
    if (mem_addr > 16'd31) bad_addr++;
    else wmem[mem_addr[4:0]] = mem_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    nwr = 0;
    for (int i = 0; i < 32; i++) begin
      wmem[i] = 8'h5A;
      exp_mem[i] = 8'hFF;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    #1 chk("rx_ready", rx_ready, 1);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'h07;
    #1 chk("ready_in_start", rx_ready, 0);
    @(negedge clock);
    start = 1'b0;
    rx_valid = 1'b0;
    chk("done_after_start", done, 0);
    chk("ovf_after_start", overflow, 0);
    chk("cnt_after_start", sink_count, 0);
  endtask

  task automatic wait_done(input bit w31);
    bit last = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      last = mem_wr && mem_addr == 16'd31;
      @(negedge clock);
    end
    chk("done", done, 1);
    if (w31) chk("done_after_1f_write", last, 1);
    chk("wr_off_in_done", mem_wr, 0);
    chk("ready_in_done", rx_ready, 0);
  endtask

  task automatic chk_mem(input string tag, input int writes);
    int mism = 0;
    for (int i = 0; i < 32; i++) if (wmem[i] !== exp_mem[i]) mism++;
    chk(tag, mism, 0);
    chk({tag, "_writes"}, nwr, writes);
  endtask

  initial begin
    #2;
    chk("rst_ready", rx_ready, 0);
    chk("rst_wr", mem_wr, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_cnt", sink_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);
    clear_log();
    @(negedge clock);
    reset = 1'b1;
    #1 chk("ready_after_rst", rx_ready, 1);
    @(negedge clock);

    // count=2, continuous
    clear_log();
    exp_mem[0] = 8'h01; exp_mem[1] = 8'h05; exp_mem[2] = 8'h0A; exp_mem[3] = 8'h0B;
    send(8'd2); send(8'h01); send(8'h05); send(8'h0A); send(8'h0B);
    wait_done(1);
    chk_mem("t1_mem", 32);
    chk("t1_cnt", sink_count, 2);
    chk("t1_ovf", overflow, 0);

    // count=0, all pad
    pulse_start();
    clear_log();
    send(8'd0);
    wait_done(1);
    chk_mem("t2_mem", 32);
    chk("t2_cnt", sink_count, 0);

    // count=16 with gaps
    pulse_start();
    clear_log();
    send(8'd16);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] b;
      b = i[0] ? 8'(i / 2 + 1) : 8'h00;
      exp_mem[i] = b;
      if (i > 0) begin
        @(negedge clock);
        chk("t3_gap_wr", mem_wr, 0);
      end
      send(b);
      chk("t3_wr", mem_wr, 1);
      chk("t3_addr", mem_addr, i);
      chk("t3_data", mem_data, b);
    end
    wait_done(1);
    chk_mem("t3_mem", 32);
    chk("t3_cnt", sink_count, 16);
    chk("t3_ovf", overflow, 0);

    // count=20, overflow
    pulse_start();
    clear_log();
    send(8'd20);
    for (int i = 0; i < 40; i++) begin
      if (i < 32) exp_mem[i] = 8'(i + 8'h30);
      send(8'(i + 8'h30));
    end
    wait_done(0);
    chk_mem("t4_mem", 32);
    chk("t4_cnt", sink_count, 16);
    chk("t4_ovf", overflow, 1);

    // restart from done, count=1
    pulse_start();
    clear_log();
    exp_mem[0] = 8'h00; exp_mem[1] = 8'h42;
    send(8'd1); send(8'h00); send(8'h42);
    wait_done(1);
    chk_mem("t5_mem", 32);
    chk("t5_cnt", sink_count, 1);

    // reset mid-frame
    pulse_start();
    clear_log();
    send(8'd4); send(8'hAA); send(8'hBB); send(8'hCC);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_wr", mem_wr, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_data", mem_data, 0);
    chk("mid_rst_cnt", sink_count, 0);
    chk("mid_rst_ready", rx_ready, 0);
    repeat (3) @(negedge clock);
    chk("mid_rst_writes", nwr, 3);
    reset = 1'b1;
    #1 chk("ready_after_mid_rst", rx_ready, 1);
    @(negedge clock);
    clear_log();
    exp_mem[0] = 8'h12; exp_mem[1] = 8'h34;
    send(8'd1); send(8'h12); send(8'h34);
    wait_done(1);
    chk_mem("t6_mem", 32);
    chk("t6_cnt", sink_count, 1);
    chk("addr_range", bad_addr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
